// File: rtl/grf_sb_if.sv
// Register-file bus for grf_sb: writeback write port, decode read/issue ports,
// scoreboard flush and pending count. master = pipeline side, slave = register file.
interface grf_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic [NREAD*ADDR_W-1:0]  ra;
    logic [NREAD*DATA_W-1:0]  rd;
    logic [NREAD-1:0]         rbusy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     sb_flush;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output we, wa, wd, ra, iss_valid, iss_addr, sb_flush,
        input  rd, rbusy, pend_cnt
    );

    modport slave (
        input  we, wa, wd, ra, iss_valid, iss_addr, sb_flush,
        output rd, rbusy, pend_cnt
    );
endinterface

// File: rtl/grf_sb.sv
// General register file with NREAD combinational read ports, one write port and a
// per-register pending-write scoreboard. Define GRF_BYPASS_EN for write-through forwarding.
module grf_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic       clk,
    input  logic       reset,
    grf_sb_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] REG0 = '0;

    logic [DATA_W-1:0]       regs [DEPTH];
    logic [DEPTH-1:0]        pend;
    logic [DEPTH-1:0]        pend_next;
    logic [ADDR_W:0]         cnt;
    logic [ADDR_W:0]         cnt_next;
    logic                    wr_ok;
    logic                    iss_ok;
    logic                    set_new;
    logic                    clr_old;
    logic [ADDR_W-1:0]       raddr;
    logic [NREAD*DATA_W-1:0] rd_v;
    logic [NREAD-1:0]        rbusy_v;

    // Flush is applied first, then the write clear, then the issue set, so an issue
    // always wins over both; the count delta is derived from the same ordering.
    always_comb begin
        wr_ok   = bus.we && !((ZERO_REG != 0) && (bus.wa == REG0));
        iss_ok  = bus.iss_valid && !((ZERO_REG != 0) && (bus.iss_addr == REG0));
        set_new = iss_ok && (bus.sb_flush || !pend[bus.iss_addr]);
        clr_old = wr_ok && !bus.sb_flush && pend[bus.wa] &&
                  !(iss_ok && (bus.iss_addr == bus.wa));

        pend_next = bus.sb_flush ? '0 : pend;
        if (wr_ok)
            pend_next[bus.wa] = 1'b0;
        if (iss_ok)
            pend_next[bus.iss_addr] = 1'b1;

        if (bus.sb_flush)
            cnt_next = {{ADDR_W{1'b0}}, set_new};
        else
            cnt_next = cnt + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_old};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok)
                regs[bus.wa] <= bus.wd;
            pend <= pend_next;
            cnt  <= cnt_next;
        end
    end

    always_comb begin
        rd_v    = '0;
        rbusy_v = '0;
        raddr   = '0;
        for (int k = 0; k < NREAD; k++) begin
            raddr = bus.ra[k*ADDR_W +: ADDR_W];
            rd_v[k*DATA_W +: DATA_W] = regs[raddr];
            rbusy_v[k]               = pend[raddr];
`ifdef GRF_BYPASS_EN
            // Forward the in-flight write; a same-cycle issue to it keeps the port busy.
            if (wr_ok && (bus.wa == raddr)) begin
                rd_v[k*DATA_W +: DATA_W] = bus.wd;
                rbusy_v[k]               = iss_ok && (bus.iss_addr == bus.wa);
            end
`endif
            if ((ZERO_REG != 0) && (raddr == REG0)) begin
                rd_v[k*DATA_W +: DATA_W] = '0;
                rbusy_v[k]               = 1'b0;
            end
        end
    end

    assign bus.rd       = rd_v;
    assign bus.rbusy    = rbusy_v;
    assign bus.pend_cnt = cnt;
endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: one ZERO_REG=1 and one ZERO_REG=0 instance driven
// with identical stimulus from a directed vector table plus hand-written sequences.
module tb_grf_sb;
    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        sb_flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;

    int tests_run;
    int tests_failed;

    grf_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bz ();
    grf_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bn ();

    assign bz.we = we;        assign bn.we = we;
    assign bz.wa = wa;        assign bn.wa = wa;
    assign bz.wd = wd;        assign bn.wd = wd;
    assign bz.ra = {ra1, ra0}; assign bn.ra = {ra1, ra0};
    assign bz.iss_valid = iss_valid; assign bn.iss_valid = iss_valid;
    assign bz.iss_addr  = iss_addr;  assign bn.iss_addr  = iss_addr;
    assign bz.sb_flush  = sb_flush;  assign bn.sb_flush  = sb_flush;

    grf_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bz)
    );

    grf_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss_v;
        logic [4:0]  iss_a;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [1:0]  exp_busy;
        logic [5:0]  exp_cnt;
        logic [5:0]  exp_cnt_n;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInputs(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic iv, input logic [4:0] ia, input logic fl);
        we = w; wa = a; wd = d; iss_valid = iv; iss_addr = ia; sb_flush = fl;
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                 input logic iv, input logic [4:0] ia, input logic fl);
        driveInputs(w, a, d, iv, ia, fl);
        stepClock();
        driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic readPorts(input logic [4:0] a0, input logic [4:0] a1);
        ra0 = a0;
        ra1 = a1;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ra0 = 5'd0;
        ra1 = 5'd0;
        driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        stepClock();
        stepClock();
        reset = 1'b0;

        readPorts(5'd5, 5'd6);
        checkOutput("init rd0", bz.rd[31:0], 32'h0);
        checkOutput("init busy", {30'd0, bz.rbusy}, 32'h0);
        checkOutput("init cnt", {26'd0, bz.pend_cnt}, 32'h0);

        // Reset clears data, pending bits and count and overrides a same-cycle write/issue
        applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 1'b0);
        readPorts(5'd5, 5'd6);
        checkOutput("pre-reset rd(5)", bz.rd[31:0], 32'hDEAD);
        checkOutput("pre-reset busy", {30'd0, bz.rbusy}, 32'h2);
        checkOutput("pre-reset cnt", {26'd0, bz.pend_cnt}, 32'h1);
        reset = 1'b1;
        driveInputs(1'b1, 5'd8, 32'hBEEF, 1'b1, 5'd8, 1'b0);
        stepClock();
        reset = 1'b0;
        driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        readPorts(5'd5, 5'd8);
        checkOutput("reset rd(5)", bz.rd[31:0], 32'h0);
        checkOutput("reset rd(8)", bz.rd[63:32], 32'h0);
        checkOutput("reset busy", {30'd0, bz.rbusy}, 32'h0);
        checkOutput("reset cnt", {26'd0, bz.pend_cnt}, 32'h0);
        checkOutput("reset cnt n", {26'd0, bn.pend_cnt}, 32'h0);

        //           we    wa     wd            iss   ia     fl    ra0    ra1    rd0           rd1           busy   cnt   cnt_n
        vecs[0]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 6'd0, 6'd1};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 1'b0, 5'd3, 5'd7, 32'h0,        32'h0,        2'b01, 6'd1, 6'd2};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b0, 5'd3, 5'd7, 32'h0,        32'h0,        2'b11, 6'd2, 6'd3};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 1'b0, 5'd3, 5'd7, 32'h0,        32'h0,        2'b11, 6'd2, 6'd3};
        vecs[4]  = '{1'b1, 5'd3, 32'h1234,      1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h1234,     32'h0,        2'b10, 6'd1, 6'd2};
        vecs[5]  = '{1'b1, 5'd9, 32'h55,        1'b1, 5'd9, 1'b0, 5'd9, 5'd3, 32'h55,       32'h1234,     2'b01, 6'd2, 6'd3};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd2, 1'b1, 5'd2, 5'd9, 32'h0,        32'h55,       2'b01, 6'd1, 6'd1};
        vecs[7]  = '{1'b1, 5'd7, 32'h77,        1'b0, 5'd0, 1'b0, 5'd7, 5'd2, 32'h77,       32'h0,        2'b10, 6'd1, 6'd1};
        vecs[8]  = '{1'b1, 5'd2, 32'hAB,        1'b0, 5'd0, 1'b1, 5'd2, 5'd7, 32'hAB,       32'h77,       2'b00, 6'd0, 6'd0};
        vecs[9]  = '{1'b1, 5'd9, 32'h99,        1'b1, 5'd2, 1'b0, 5'd2, 5'd9, 32'hAB,       32'h99,       2'b01, 6'd1, 6'd1};
        vecs[10] = '{1'b1, 5'd2, 32'hCD,        1'b1, 5'd5, 1'b0, 5'd2, 5'd5, 32'hCD,       32'h0,        2'b10, 6'd1, 6'd1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00, 6'd0, 6'd0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iss_v, vecs[i].iss_a, vecs[i].flush);
            readPorts(vecs[i].ra0, vecs[i].ra1);
            checkOutput($sformatf("v%0d rd0", i), bz.rd[31:0], vecs[i].exp_rd0);
            checkOutput($sformatf("v%0d rd1", i), bz.rd[63:32], vecs[i].exp_rd1);
            checkOutput($sformatf("v%0d busy", i), {30'd0, bz.rbusy}, {30'd0, vecs[i].exp_busy});
            checkOutput($sformatf("v%0d cnt", i), {26'd0, bz.pend_cnt}, {26'd0, vecs[i].exp_cnt});
            checkOutput($sformatf("v%0d cnt_n", i), {26'd0, bn.pend_cnt}, {26'd0, vecs[i].exp_cnt_n});
        end

        readPorts(5'd0, 5'd0);
        checkOutput("r0 ordinary rd", bn.rd[31:0], 32'hFFFF_FFFF);

        // Same-cycle write and read of r4, with and without forwarding
        applyStimulus(1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 1'b0);
        readPorts(5'd4, 5'd4);
        driveInputs(1'b1, 5'd4, 32'h20, 1'b0, 5'd0, 1'b0);
        #1;
`ifdef GRF_BYPASS_EN
        checkOutput("byp rd0", bz.rd[31:0], 32'h20);
        checkOutput("byp rd1", bz.rd[63:32], 32'h20);
`else
        checkOutput("byp rd0", bz.rd[31:0], 32'h10);
        checkOutput("byp rd1", bz.rd[63:32], 32'h10);
`endif
        checkOutput("byp busy", {30'd0, bz.rbusy}, 32'h0);
        driveInputs(1'b1, 5'd4, 32'h20, 1'b1, 5'd4, 1'b0);
        #1;
`ifdef GRF_BYPASS_EN
        checkOutput("byp iss busy", {30'd0, bz.rbusy}, 32'h3);
`else
        checkOutput("byp iss busy", {30'd0, bz.rbusy}, 32'h0);
`endif
        stepClock();
        driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("iss+wr rd", bz.rd[31:0], 32'h20);
        checkOutput("iss+wr busy", {30'd0, bz.rbusy}, 32'h3);
        checkOutput("iss+wr cnt", {26'd0, bz.pend_cnt}, 32'h1);
        driveInputs(1'b1, 5'd4, 32'h30, 1'b0, 5'd0, 1'b0);
        #1;
`ifdef GRF_BYPASS_EN
        checkOutput("byp pend busy", {30'd0, bz.rbusy}, 32'h0);
        checkOutput("byp pend rd", bz.rd[31:0], 32'h30);
`else
        checkOutput("byp pend busy", {30'd0, bz.rbusy}, 32'h3);
        checkOutput("byp pend rd", bz.rd[31:0], 32'h20);
`endif
        stepClock();
        driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("wb clr cnt", {26'd0, bz.pend_cnt}, 32'h0);
        checkOutput("wb clr rd", bz.rd[31:0], 32'h30);

        // Fill the whole scoreboard, then drain it through writeback
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b0);
        readPorts(5'd31, 5'd0);
        checkOutput("fill cnt", {26'd0, bz.pend_cnt}, 32'd31);
        checkOutput("fill cnt n", {26'd0, bn.pend_cnt}, 32'd32);
        checkOutput("fill busy", {30'd0, bz.rbusy}, 32'h1);
        checkOutput("fill busy n", {30'd0, bn.rbusy}, 32'h3);
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 1'b0);
        readPorts(5'd31, 5'd0);
        checkOutput("drain cnt", {26'd0, bz.pend_cnt}, 32'd0);
        checkOutput("drain cnt n", {26'd0, bn.pend_cnt}, 32'd0);
        checkOutput("drain rd31", bz.rd[31:0], 32'h11F);
        checkOutput("drain rd0", bz.rd[63:32], 32'h0);
        checkOutput("drain rd0 n", bn.rd[63:32], 32'h100);
        checkOutput("drain busy n", {30'd0, bn.rbusy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
